odd_even_merge_sort_pipe: RTL and testbench
===========================================

// Module: odd_even_merge_sort_pipe
// PURPOSE
//  Parametrised, fully pipelined Batcher odd-even merge sorting network for N unsigned keys of DATA_W bits.
//  Generalises the fixed 4 x 8-bit sorter:
//  - N and key width are parameters.
//  - Sort direction is selectable per vector.
//  - valid/ready handshake with full-pipeline back-pressure.
//  - Synchronous pipeline flush.
//  Accepts one vector per clock when unstalled; sits between a key-collection front end and downstream consumers.
// PARAMETERS
//  DATA_W   8   key width in bits (1..32)
//  N        8   keys per vector; power of two, 2..16; other values are rejected by an elaboration $error
//  STAGES   derived = L*(L+1)/2 with L=$clog2(N); one register rank per comparator stage (N=8 -> 6)
// PORTS
//  clk        in   1           clock; all state updates on the rising edge
//  rst        in   1           asynchronous active-high reset
//  clr        in   1           synchronous flush of all in-flight vectors
//  in_valid   in   1           input vector valid
//  in_ready   out  1           sorter can accept a vector this cycle
//  in_data    in   N*DATA_W    key i at [i*DATA_W +: DATA_W]
//  in_desc    in   1           1 = descending, 0 = ascending; captured with the vector
//  out_valid  out  1           sorted vector valid
//  out_ready  in   1           downstream accepts
//  out_data   out  N*DATA_W    sorted keys; slot 0 = min (asc) or max (desc)
//  out_desc   out  1           direction bit that travelled with the vector
//  occupancy  out  $clog2(STAGES+1)  number of valid pipeline ranks
// BEHAVIOUR
//  - Reset: all rank valid bits 0, data/desc registers 0. out_valid=0, out_data=0, out_desc=0, occupancy=0, in_ready=1.
//  - Pipeline enable: en = !out_valid | out_ready. in_ready = en. All ranks advance together only when en=1.
//  - A vector is accepted when in_valid & in_ready. It appears on out_data exactly STAGES enabled cycles later.
//    Unstalled latency = STAGES clocks.
//  - Stall: while out_valid & !out_ready, every rank holds. out_data/out_desc stay stable. No vector is dropped or duplicated.
//  - Comparator (asc): swap a pair (lo,hi) only if key[lo] > key[hi], strictly.
//    Descending inverts the test (key[lo] < key[hi]). Equal keys never swap.
//  - Network: standard Batcher odd-even merge. Exactly one register rank after each comparator stage.
//    No combinational path from in_data to out_data.
//  - Bubbles: a rank with valid=0 still clocks data when en=1 but is never presented. Back-to-back vectors need no gap.
//  - occupancy = popcount of rank valid bits, updated each cycle.
//  - Full pipeline with out_ready=1 is throughput 1 vector/clock; occupancy holds at STAGES.
//  - clr: at the next edge, all rank valid bits go to 0. A vector presented in the same cycle is also discarded,
//    whether or not it is accepted. Data registers are not cleared. clr has priority over en.
//  - rst asserted mid-operation: all in-flight vectors are lost immediately. Outputs take reset values asynchronously.
//  - Arithmetic: unsigned compare only. Width is preserved; keys are never modified, only permuted.
// CONFIGURATION
//  SORT_INDEX_EN defined:
//   - Adds out_idx (out, N*$clog2(N)): for each out_data slot, the original in_data position of that key.
//   - Index tags travel with keys through every swap.
//   - Ties keep the stable order: the lower original index lands in the lower slot for asc; same rule for desc.
//   - out_idx resets to 0.
//  SORT_INDEX_EN undefined: no out_idx port and no tag registers. Key behaviour is identical.
// TESTING (N=8, DATA_W=8)
//  T1 reset:
//   - rst=1 for 2 clk, then low -> out_valid=0, occupancy=0, in_ready=1.
//  T2 single asc vector:
//   - in_data slots 0..7 = 5A,03,FF,10,03,80,00,7F, in_desc=0.
//   - 6 clk later, out_valid=1 with slots 0..7 = 00,03,03,10,5A,7F,80,FF.
//   - out_desc=0. Index build: out_idx = 6,1,4,3,0,7,5,2.
//  T3 desc plus back-to-back:
//   - Stream 30 random vectors, one per clock, direction alternating.
//   - Each output matches a reference sort, arrives in order, no gaps.
//   - occupancy reaches 6.
//  T4 back-pressure:
//   - Hold out_ready=0 for 10 clk while the pipe is full -> in_ready=0.
//   - out_data stays stable, occupancy=6.
//   - On release, all 6 vectors drain in order with none lost or repeated.
//  T5 clr and reset mid-flight:
//   - Pulse clr with 4 vectors in flight -> occupancy=0 next clk; no further out_valid.
//   - Repeat using rst -> outputs go to 0 asynchronously.
//  T6 duplicates/extremes:
//   - All-equal vector AA x8 and vector 00,FF alternating -> correct order.
//   - Index build: tie order is stable.

Source files
------------

// File: rtl/odd_even_merge_sort_pipe.sv
// odd_even_merge_sort_pipe: fully pipelined Batcher odd-even merge sorting network for N unsigned keys.
// Latency: STAGES = L*(L+1)/2 enabled clocks (L = log2 N), one register rank per comparator stage.
// Backpressure: all ranks advance together only when !out_valid | out_ready; in_ready mirrors that enable.
//
// Ports:
//   clk, rst (async active-high), clr (sync flush of in-flight vectors)
//   in_valid/in_ready/in_data/in_desc   : input vector, key i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data/out_desc : sorted vector, slot 0 = min (asc) or max (desc)
//   occupancy                            : number of valid pipeline ranks
//   out_idx (only with SORT_INDEX_EN)    : original input slot of each output key
//
// Optional build macro: SORT_INDEX_EN adds index tags that travel with the keys.
module odd_even_merge_sort_pipe #(
    parameter int  DATA_W = 8,
    parameter int  N      = 8,
    localparam int L      = $clog2(N),
    localparam int STAGES = L * (L + 1) / 2,
    localparam int OCC_W  = $clog2(STAGES + 1),
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_desc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic                out_desc,
    output logic [OCC_W-1:0]    occupancy
`ifdef SORT_INDEX_EN
    ,
    output logic [N*IDX_W-1:0]  out_idx
`endif
);

    if (N < 2 || N > 16 || (N & (N - 1)) != 0 || DATA_W < 1 || DATA_W > 32) begin : g_bad_param
        $error("odd_even_merge_sort_pipe: N must be a power of two in 2..16 and DATA_W in 1..32");
    end

    // Partner of element e in comparator stage st (e itself when e is idle in that stage).
    // Walks the classic iterative Batcher odd-even merge formulation; one (p,k) pair per stage.
    function automatic int cmp_partner(input int st, input int e);
        int s_cnt;
        int res;
        res   = e;
        s_cnt = 0;
        for (int p = 1; p < N; p = p * 2) begin
            for (int k = p; k >= 1; k = k / 2) begin
                if (s_cnt == st) begin
                    for (int j = k % p; j <= N - 1 - k; j = j + 2 * k) begin
                        for (int i = 0; (i <= k - 1) && (i <= N - j - k - 1); i++) begin
                            if ((i + j) / (2 * p) == (i + j + k) / (2 * p)) begin
                                if (i + j == e)     res = i + j + k;
                                if (i + j + k == e) res = i + j;
                            end
                        end
                    end
                end
                s_cnt++;
            end
        end
        return res;
    endfunction

    logic                en;
    logic [STAGES-1:0]   vld_q, vld_d;
    logic                desc_q   [STAGES];
    logic                desc_d   [STAGES];
    logic [DATA_W-1:0]   key_q    [STAGES][N];
    logic [DATA_W-1:0]   key_d    [STAGES][N];

    // Stage inputs (rank s-1, or the input port for stage 0) and comparator outputs.
    logic                src_desc [STAGES];
    logic [DATA_W-1:0]   src_key  [STAGES][N];
    logic [DATA_W-1:0]   net_key  [STAGES][N];

`ifdef SORT_INDEX_EN
    logic [IDX_W-1:0]    idx_q    [STAGES][N];
    logic [IDX_W-1:0]    idx_d    [STAGES][N];
    logic [IDX_W-1:0]    src_idx  [STAGES][N];
    logic [IDX_W-1:0]    net_idx  [STAGES][N];
`endif

    assign out_valid = vld_q[STAGES-1];
    assign out_desc  = desc_q[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_src_in
            assign src_desc[s] = in_desc;
            for (genvar e = 0; e < N; e++) begin : g_e
                assign src_key[s][e] = in_data[e*DATA_W +: DATA_W];
`ifdef SORT_INDEX_EN
                assign src_idx[s][e] = IDX_W'(e);
`endif
            end
        end else begin : g_src_rank
            assign src_desc[s] = desc_q[s-1];
            for (genvar e = 0; e < N; e++) begin : g_e
                assign src_key[s][e] = key_q[s-1][e];
`ifdef SORT_INDEX_EN
                assign src_idx[s][e] = idx_q[s-1][e];
`endif
            end
        end

        // Each element computes the same swap decision as its partner, so every slot is
        // driven by exactly one mux.
        for (genvar e = 0; e < N; e++) begin : g_cmp
            localparam int Q = cmp_partner(s, e);
            if (Q == e) begin : g_pass
                assign net_key[s][e] = src_key[s][e];
`ifdef SORT_INDEX_EN
                assign net_idx[s][e] = src_idx[s][e];
`endif
            end else begin : g_swap
                localparam int LO = (Q < e) ? Q : e;
                localparam int HI = (Q < e) ? e : Q;
                logic swap;
                always_comb begin
                    swap = 1'b0;
                    if (src_desc[s]) begin
                        swap = src_key[s][LO] < src_key[s][HI];
                    end else begin
                        swap = src_key[s][LO] > src_key[s][HI];
                    end
`ifdef SORT_INDEX_EN
                    // Equal keys are ordered by original position; the network then sorts on a
                    // total order, which makes tie placement stable. Key output is unaffected.
                    if ((src_key[s][LO] == src_key[s][HI]) && (src_idx[s][LO] > src_idx[s][HI])) begin
                        swap = 1'b1;
                    end
`endif
                end
                assign net_key[s][e] = swap ? src_key[s][Q] : src_key[s][e];
`ifdef SORT_INDEX_EN
                assign net_idx[s][e] = swap ? src_idx[s][Q] : src_idx[s][e];
`endif
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        desc_d = desc_q;
        key_d  = key_q;
`ifdef SORT_INDEX_EN
        idx_d  = idx_q;
`endif
        if (en) begin
            // Bubble ranks still clock data; only the valid bits decide what is presented.
            vld_d[0] = in_valid;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                desc_d[s] = src_desc[s];
                for (int e = 0; e < N; e++) begin
                    key_d[s][e] = net_key[s][e];
`ifdef SORT_INDEX_EN
                    idx_d[s][e] = net_idx[s][e];
`endif
                end
            end
        end
        // Flush wins over the enable, and also drops whatever is on the input this cycle.
        if (clr) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                desc_q[s] <= 1'b0;
                for (int e = 0; e < N; e++) begin
                    key_q[s][e] <= '0;
`ifdef SORT_INDEX_EN
                    idx_q[s][e] <= '0;
`endif
                end
            end
        end else begin
            vld_q  <= vld_d;
            desc_q <= desc_d;
            key_q  <= key_d;
`ifdef SORT_INDEX_EN
            idx_q  <= idx_d;
`endif
        end
    end

    always_comb begin
        out_data = '0;
        for (int e = 0; e < N; e++) begin
            out_data[e*DATA_W +: DATA_W] = key_q[STAGES-1][e];
        end
    end

`ifdef SORT_INDEX_EN
    always_comb begin
        out_idx = '0;
        for (int e = 0; e < N; e++) begin
            out_idx[e*IDX_W +: IDX_W] = idx_q[STAGES-1][e];
        end
    end
`endif

    always_comb begin
        occupancy = '0;
        for (int s = 0; s < STAGES; s++) begin
            occupancy = occupancy + OCC_W'(vld_q[s]);
        end
    end

endmodule

// File: tb/tb_odd_even_merge_sort_pipe.sv
// tb_odd_even_merge_sort_pipe: scoreboard bench for the 8 x 8-bit configuration.
// Driver pushes the expected sorted vector when it issues a vector; a negedge monitor pops
// and compares every output transfer.
module tb_odd_even_merge_sort_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_desc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_desc;
    logic [2:0]  occupancy;
`ifdef SORT_INDEX_EN
    logic [23:0] out_idx;
`endif

    odd_even_merge_sort_pipe #(.DATA_W(8), .N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_desc  (out_desc),
        .occupancy (occupancy)
`ifdef SORT_INDEX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        desc;
        logic [23:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   pops = 0;
    int   cyc = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic desc, input int a [8]);
        exp_t r;
        r.data = d;
        r.desc = desc;
        r.idx  = '0;
        for (int i = 0; i < 8; i++) r.idx[i*3 +: 3] = a[i][2:0];
        return r;
    endfunction

    // Stable insertion sort: equal keys never pass each other.
    function automatic exp_t ref_sort(input logic [63:0] d, input logic desc);
        logic [7:0] k [8];
        int         ix [8];
        logic [7:0] tk;
        int         ti;
        exp_t       r;
        for (int i = 0; i < 8; i++) begin
            k[i]  = d[i*8 +: 8];
            ix[i] = i;
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (k[j] > k[j-1]) : (k[j] < k[j-1])) begin
                    tk = k[j];  k[j]  = k[j-1];  k[j-1]  = tk;
                    ti = ix[j]; ix[j] = ix[j-1]; ix[j-1] = ti;
                end else begin
                    break;
                end
            end
        end
        r.data = '0;
        r.idx  = '0;
        r.desc = desc;
        for (int i = 0; i < 8; i++) begin
            r.data[i*8 +: 8] = k[i];
            r.idx[i*3 +: 3]  = ix[i][2:0];
        end
        return r;
    endfunction

    task automatic send(input logic [63:0] d, input logic desc, input exp_t e);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_desc  = desc;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("send_timeout_in_ready", in_ready, 1);
        else sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic desc);
        logic [63:0] d;
        d = {$urandom, $urandom};
        send(d, desc, ref_sort(d, desc));
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_desc", out_desc, e.desc);
`ifdef SORT_INDEX_EN
                chk("out_idx", out_idx, e.idx);
`endif
                pops++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int occ_max;
        int seen;

        // T1 reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_occupancy", occupancy, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_out_data", out_data, 0);
        chk("t1_out_desc", out_desc, 0);

        // T2 single vector, both directions, with latency
        send(64'h7F00_8003_10FF_035A, 1'b0,
             mk(64'hFF80_7F5A_1003_0300, 1'b0, '{6, 1, 4, 3, 0, 7, 5, 2}));
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t2_latency", lat, 6);
        drain("t2_drain_asc");
        send(64'h7F00_8003_10FF_035A, 1'b1,
             mk(64'h0003_0310_5A7F_80FF, 1'b1, '{2, 5, 7, 0, 3, 1, 4, 6}));
        drain("t2_drain_desc");

        // T3 back-to-back stream, alternating direction
        pops = 0;
        first_cyc = -1;
        occ_max = 0;
        for (int i = 0; i < 30; i++) begin
            send_rand(i[0]);
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
        end
        drain("t3_drain");
        chk("t3_occupancy_max", occ_max, 6);
        chk("t3_count", pops, 30);
        chk("t3_no_gaps", last_cyc - first_cyc, 29);

        // T4 back-pressure on a full pipe
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_rand(i[1]);
        for (int i = 0; i < 10; i++) begin
            chk("t4_in_ready", in_ready, 0);
            chk("t4_occupancy", occupancy, 6);
            chk("t4_out_data_hold", out_data, sb_q[0].data);
            @(posedge clk); #1;
        end
        pops = 0;
        out_ready = 1'b1;
        drain("t4_drain");
        chk("t4_drained_count", pops, 6);

        // T5a flush with 4 vectors in flight; the vector presented alongside clr is dropped too
        for (int i = 0; i < 4; i++) send_rand(1'b0);
        chk("t5_occ_before_clr", occupancy, 4);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 64'h0102_0304_0506_0708;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        chk("t5_occ_after_clr", occupancy, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("t5_clr_no_output", seen, 0);

        // T5b asynchronous reset with a full, stalled pipe
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(64'h1122_3344_5566_7788, 1'b1,
                                         ref_sort(64'h1122_3344_5566_7788, 1'b1));
        chk("t5_full_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_out_data", out_data, 0);
        chk("t5_rst_out_desc", out_desc, 0);
        chk("t5_rst_occupancy", occupancy, 0);
        chk("t5_rst_in_ready", in_ready, 1);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // T6 duplicates and extremes
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
             mk(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, '{0, 1, 2, 3, 4, 5, 6, 7}));
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
             mk(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, '{0, 1, 2, 3, 4, 5, 6, 7}));
        send(64'hFF00_FF00_FF00_FF00, 1'b0,
             mk(64'hFFFF_FFFF_0000_0000, 1'b0, '{0, 2, 4, 6, 1, 3, 5, 7}));
        send(64'hFF00_FF00_FF00_FF00, 1'b1,
             mk(64'h0000_0000_FFFF_FFFF, 1'b1, '{1, 3, 5, 7, 0, 2, 4, 6}));
        drain("t6_drain");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
